// File: rtl/apb_pkg.sv
// Shared types for the APB initiator: FSM state encoding, default widths, response record.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  error;
  } rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB3 initiator: one command in flight, SETUP/ACCESS sequencing, registered response.
// Optional ACCESS timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
import apb_pkg::*;

module apb_master #(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              pSel,
  output logic              pEnable,
  output logic              pWrite,
  output logic [ADDR_W-1:0] pAddr,
  output logic [DATA_W-1:0] pWdata,
  input  logic [DATA_W-1:0] pReadData,
  input  logic              pReady,
  input  logic              pSlvErr
);

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("apb_master: TIMEOUT_CYC must be at least 1");
  end

  apb_state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
`endif

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      pSel      <= 1'b0;
      pEnable   <= 1'b0;
      pWrite    <= 1'b0;
      pAddr     <= '0;
      pWdata    <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            pWrite    <= cmd_write;
            pAddr     <= cmd_addr;
            pWdata    <= cmd_wdata;
            pSel      <= 1'b1;
            pEnable   <= 1'b0;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          pEnable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        ACCESS: begin
          // pSlvErr is only meaningful on the completing cycle
          if (pReady) begin
            rsp_rdata <= pWrite ? '0 : pReadData;
            rsp_error <= pSlvErr;
            pSel      <= 1'b0;
            pEnable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
            pSel      <= 1'b0;
            pEnable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a response scoreboard; timeout steps need APB_MASTER_TIMEOUT_EN.
module tb_apb_master;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          pClk = 1'b0;
  logic          pReset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          pSel, pEnable, pWrite;
  logic [AW-1:0] pAddr;
  logic [DW-1:0] pWdata, pReadData;
  logic          pReady, pSlvErr;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .pClk(pClk), .pReset(pReset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .pSel(pSel), .pEnable(pEnable), .pWrite(pWrite), .pAddr(pAddr), .pWdata(pWdata),
    .pReadData(pReadData), .pReady(pReady), .pSlvErr(pSlvErr)
  );

  always #5 pClk = ~pClk;

  // Minimal responder register: TxData at address 4
  logic [DW-1:0] tx_reg = '0;
  always @(posedge pClk)
    if (pSel && pEnable && pReady && pWrite && pAddr == 32'h4) tx_reg <= pWdata;

  rsp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge pClk); #1;
  endtask

  // Present a command and step through SETUP into the first ACCESS cycle
  task automatic start_cmd(input logic w, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = addr; cmd_wdata = wdata;
    chk("idle_cmd_ready", cmd_ready, 1);
    tick();
    chk("setup_psel", pSel, 1);
    chk("setup_penable", pEnable, 0);
    chk("setup_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    tick();
    chk("access_sel_en", {pSel, pEnable}, 2'b11);
    chk("access_addr", pAddr, addr);
    chk("access_write", pWrite, w);
  endtask

  task automatic access(input int waits, input logic w, input logic [AW-1:0] addr,
                        input logic [DW-1:0] rdata, input logic err);
    rsp_t e;
    for (int i = 0; i < waits; i++) begin
      pReady = 1'b0; pSlvErr = 1'b1; pReadData = $urandom;
      tick();
      chk("wait_sel_en", {pSel, pEnable}, 2'b11);
      chk("wait_addr", pAddr, addr);
      chk("wait_no_rsp", rsp_valid, 0);
    end
    pReady = 1'b1; pSlvErr = err; pReadData = rdata;
    e.rdata = w ? '0 : rdata;
    e.error = err;
    exp_q.push_back(e);
    tick();
    pReady = 1'b0; pSlvErr = 1'b0;
    chk("done_sel_en", {pSel, pEnable}, 2'b00);
  endtask

  task automatic check_rsp();
    rsp_t e;
    chk("rsp_valid", rsp_valid, 1);
    chk("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_error", rsp_error, e.error);
    end
  endtask

  task automatic handshake(input logic [AW-1:0] addr);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", rsp_valid, 0);
    chk("hs_cmd_ready", cmd_ready, 1);
    chk("hs_addr_kept", pAddr, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pReset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; pReadData = '0; pReady = 0; pSlvErr = 0;
    repeat (2) @(posedge pClk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_error}, 2'b00);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_apb_ctl", {pSel, pEnable, pWrite}, 3'b000);
    chk("rst_apb_addr", pAddr, 0);
    chk("rst_apb_wdata", pWdata, 0);
    pReset = 1'b0;
    tick();

    // Write, zero wait states
    start_cmd(1'b1, 32'h4, 32'hA5);
    chk("wr_pwdata", pWdata, 32'hA5);
    access(0, 1'b1, 32'h4, 32'h1111_2222, 1'b0);
    check_rsp();
    handshake(32'h4);
    chk("txdata_reg", tx_reg, 32'hA5);

    // Read with three wait states
    start_cmd(1'b0, 32'h0, 32'h0);
    access(3, 1'b0, 32'h0, 32'h5C, 1'b0);
    check_rsp();
    handshake(32'h0);

    // Slave error on a read
    start_cmd(1'b0, 32'h8, 32'h0);
    access(1, 1'b0, 32'h8, 32'h1234_5678, 1'b1);
    check_rsp();
    handshake(32'h8);

    // Response backpressure with a new command waiting
    start_cmd(1'b1, 32'h10, 32'hDEAD_BEEF);
    access(1, 1'b1, 32'h10, 32'hFFFF_FFFF, 1'b0);
    check_rsp();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", {rsp_error, rsp_rdata}, 33'h0);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_no_psel", pSel, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_hs_valid", rsp_valid, 0);
    chk("bp_hs_ready", cmd_ready, 1);
    chk("bp_hs_no_psel", pSel, 0);
    tick();
    chk("bp_next_setup", {pSel, pEnable}, 2'b10);
    chk("bp_next_addr", pAddr, 32'h20);
    cmd_valid = 1'b0;
    tick();
    chk("bp_next_access", {pSel, pEnable}, 2'b11);
    access(0, 1'b0, 32'h20, 32'h77, 1'b0);
    check_rsp();
    handshake(32'h20);

    // Asynchronous reset while waiting in ACCESS
    start_cmd(1'b0, 32'h30, 32'h0);
    pReady = 1'b0;
    tick();
    #3 pReset = 1'b1;
    #1;
    chk("arst_sel_en", {pSel, pEnable}, 2'b00);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_addr", pAddr, 0);
    #2 pReset = 1'b0;
    tick();
    chk("post_rst_rsp", rsp_valid, 0);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_psel", pSel, 0);

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout: pReady never rises, eighth ACCESS cycle ends the transfer
    start_cmd(1'b0, 32'h40, 32'h0);
    pReady = 1'b0; pReadData = 32'hABCD;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("to_waiting", {rsp_valid, pSel, pEnable}, 3'b011);
    end
    exp_q.push_back('{rdata: '0, error: 1'b1});
    tick();
    chk("to_sel_en", {pSel, pEnable}, 2'b00);
    check_rsp();
    handshake(32'h40);

    // pReady on the last counted cycle wins over the timeout
    start_cmd(1'b0, 32'h44, 32'h0);
    access(TO - 1, 1'b0, 32'h44, 32'h33, 1'b0);
    check_rsp();
    handshake(32'h44);
`else
    // Without the timeout a long wait still completes normally
    start_cmd(1'b0, 32'h44, 32'h0);
    access(20, 1'b0, 32'h44, 32'h33, 1'b0);
    check_rsp();
    handshake(32'h44);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that turns single-beat command requests into APB3 transfers toward APB responders such as the UART register block.
- Sits between a command source (UART command parser, test sequencer) and the peripheral APB bus.
- Accepts one command at a time through a valid/ready handshake.
- Returns read data and error status through a response handshake.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYC, 255, max ACCESS cycles waiting for pReady (used only with APB_MASTER_TIMEOUT_EN)

Ports:
pClk  in  1  clock
pReset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  master can accept command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_error  out  1  pSlvErr or timeout seen
pSel  out  1  APB select
pEnable  out  1  APB enable
pWrite  out  1  APB direction
pAddr  out  ADDR_W  APB address
pWdata  out  DATA_W  APB write data
pReadData  in  DATA_W  APB read data
pReady  in  1  responder ready
pSlvErr  in  1  responder error

Behaviour:
- One clock (pClk). Asynchronous, active-high reset (pReset).
- All outputs are registered.
- Reset values:
  - state=IDLE
  - cmd_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_error=0
  - pSel=0, pEnable=0, pWrite=0, pAddr=0, pWdata=0
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch write/addr/wdata onto pWrite/pAddr/pWdata.
  - Drive pSel=1, pEnable=0, cmd_ready=0; go to SETUP.
- SETUP:
  - Exactly one cycle. pReady is ignored.
  - Drive pEnable=1; go to ACCESS.
- ACCESS:
  - pSel=1, pEnable=1. pAddr/pWrite/pWdata are held stable.
  - Wait states: while pReady=0, stay in ACCESS.
  - On pReady=1:
    - rsp_rdata = pReadData if read, 0 if write.
    - rsp_error = pSlvErr.
    - Drive pSel=0, pEnable=0, rsp_valid=1; go to RESP.
- RESP:
  - rsp_valid/rsp_rdata/rsp_error held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: rsp_valid=0, cmd_ready=1; go to IDLE.
  - No command is accepted while a response is pending (no overlap).
- Latency: command accepted at cycle N, SETUP at N+1, ACCESS at N+2. With pReady=1 at N+2, rsp_valid=1 at N+3. Each wait state adds 1 cycle.
- Minimum command-to-command throughput: 4 cycles (rsp_ready tied high).
- pAddr/pWdata/pWrite keep their last values after a transfer. They are not cleared.
- pSlvErr is sampled only when pReady=1 in ACCESS, and ignored otherwise.
- Reset asserted mid-transfer: outputs go immediately to reset values; the in-flight transfer is dropped and produces no response.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - ACCESS counter starts at 0 on entering ACCESS and increments each cycle with pReady=0.
  - When the counter reaches TIMEOUT_CYC-1 with pReady still 0: pSel=0, pEnable=0, rsp_rdata=0, rsp_error=1, rsp_valid=1; go to RESP.
  - Counter width is clog2(TIMEOUT_CYC+1).
  - pReady=1 on the final counted cycle wins over timeout.
- Undefined: no counter; ACCESS waits indefinitely for pReady.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE, SETUP, ACCESS, RESP)
  - APB_ADDR_W/APB_DATA_W defaults
  - response struct {rdata, error}
- No sub-module: a single FSM plus an optional counter stays in one module. apb_timeout_cnt is not warranted.

Test Plan:
- Write, zero wait:
  - Stimulus: cmd write addr=0x0000_0004, wdata=0x0000_00A5; pReady=1; responder UART_Register.
  - Response: pSel rises N+1, pEnable N+2, rsp_valid N+3 with rsp_error=0, rsp_rdata=0. TxData register reads 0xA5.
- Read with wait states:
  - Stimulus: cmd read addr=0x0; pReady low 3 cycles then high; pReadData=0x0000_005C.
  - Response: ACCESS lasts 4 cycles, address stable throughout, rsp_rdata=0x5C.
- Response backpressure:
  - Stimulus: rsp_ready held low 5 cycles after rsp_valid; new cmd_valid presented.
  - Response: rsp_* stable, cmd_ready=0 until rsp_ready. Next SETUP starts 1 cycle after handshake+IDLE.
- Slave error:
  - Stimulus: read with pSlvErr=1 and pReady=1.
  - Response: rsp_error=1, rsp_rdata=pReadData value, FSM returns to IDLE.
- Reset mid-ACCESS:
  - Stimulus: assert pReset asynchronously (between edges) while pReady=0.
  - Response: pSel/pEnable drop without a clock edge, cmd_ready=1 after release, no rsp_valid.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYC=8):
  - Stimulus: pReady held 0.
  - Response: after 8 ACCESS cycles rsp_valid=1, rsp_error=1, rsp_rdata=0. With pReady=1 on the 8th cycle, rsp_error=pSlvErr.
